ts_record_rx: RTL and testbench

- Receiver for the timestamper's serial output stream; the far-end decoder sitting on a host-side FPGA or in the bench.
- Deserialises 8N1 UART bytes from `serialin`, then parses fixed 7-byte timestamp records.
- Presents each good record as channel number plus 32-bit timestamp with a one-cycle valid strobe.
- Flags framing and checksum errors.

---
 rtl/ts_record_rx.sv | 167 ++++++++++++++++
 tb/tb_ts_record_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ts_record_rx.sv
// Timestamp record receiver: 8N1 UART deserialiser feeding a 7-byte record parser
// (SYNC, CHAN, TS3..TS0, CSUM) that emits channel/timestamp with error strobes.
module ts_record_rx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'h7E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serialin,
    output logic        rec_valid,
    output logic [1:0]  rec_channel,
    output logic [31:0] rec_timestamp,
    output logic        frame_err,
    output logic        chk_err,
    output logic        busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_START = 2'd1;
    localparam logic [1:0] B_DATA  = 2'd2;
    localparam logic [1:0] B_STOP  = 2'd3;

    localparam logic [1:0] P_HUNT = 2'd0;
    localparam logic [1:0] P_CHAN = 2'd1;
    localparam logic [1:0] P_TS   = 2'd2;
    localparam logic [1:0] P_CSUM = 2'd3;

    logic [1:0]    sync_q;
    logic          line;
    logic [1:0]    bit_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_tick;
    logic          byte_done;
    logic          byte_bad;

    logic [1:0]    p_state;
    logic [1:0]    ts_cnt;
    logic [7:0]    run_xor;
    logic [1:0]    chan_q;
    logic [31:0]   ts_acc;

    assign line = sync_q[1];

    // Bit timing: START waits half a bit so every later sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            bit_state <= B_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
        end else begin
            sync_q <= {sync_q[0], serialin};
            case (bit_state)
                B_IDLE: begin
                    cnt <= '0;
                    if (!line) begin
                        bit_state <= B_START;
                    end
                end
                B_START: begin
                    if (cnt == HALF_M1) begin
                        cnt       <= '0;
                        bit_idx   <= 3'd0;
                        bit_state <= line ? B_IDLE : B_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        shreg <= {line, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_state <= B_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == BIT_M1) begin
                        cnt       <= '0;
                        bit_state <= B_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign stop_tick = (bit_state == B_STOP) && (cnt == BIT_M1);
    assign byte_done = stop_tick && line;
    assign byte_bad  = stop_tick && !line;

    // Record parser; a framing error always wins over parsing that byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state       <= P_HUNT;
            ts_cnt        <= 2'd0;
            run_xor       <= 8'd0;
            chan_q        <= 2'd0;
            ts_acc        <= 32'd0;
            rec_valid     <= 1'b0;
            rec_channel   <= 2'd0;
            rec_timestamp <= 32'd0;
            frame_err     <= 1'b0;
            chk_err       <= 1'b0;
        end else begin
            rec_valid <= 1'b0;
            chk_err   <= 1'b0;
            frame_err <= byte_bad;
            if (byte_bad) begin
                p_state <= P_HUNT;
            end else if (byte_done) begin
                case (p_state)
                    P_HUNT: begin
                        if (shreg == SYNC_BYTE) begin
                            p_state <= P_CHAN;
                        end
                    end
                    P_CHAN: begin
                        run_xor <= shreg;
                        chan_q  <= shreg[1:0];
                        ts_cnt  <= 2'd0;
                        if (|shreg[7:2]) begin
                            chk_err <= 1'b1;
                            p_state <= P_HUNT;
                        end else begin
                            p_state <= P_TS;
                        end
                    end
                    P_TS: begin
                        ts_acc  <= {ts_acc[23:0], shreg};
                        run_xor <= run_xor ^ shreg;
                        ts_cnt  <= ts_cnt + 2'd1;
                        if (ts_cnt == 2'd3) begin
                            p_state <= P_CSUM;
                        end
                    end
                    default: begin
                        if (shreg == run_xor) begin
                            rec_valid     <= 1'b1;
                            rec_channel   <= chan_q;
                            rec_timestamp <= ts_acc;
                        end else begin
                            chk_err <= 1'b1;
                        end
                        p_state <= P_HUNT;
                    end
                endcase
            end
        end
    end

    assign busy = (p_state != P_HUNT);

endmodule

// File: tb/tb_ts_record_rx.sv
// Bench for ts_record_rx: directed serial records, expected events queued by the
// driver and matched by an independent output monitor.
module tb_ts_record_rx;

    localparam int CPB = 16;
    localparam logic [1:0] K_VALID = 2'd1;
    localparam logic [1:0] K_CHK   = 2'd2;
    localparam logic [1:0] K_FRAME = 2'd3;

    logic        clk;
    logic        rst;
    logic        serialin;
    logic        rec_valid;
    logic [1:0]  rec_channel;
    logic [31:0] rec_timestamp;
    logic        frame_err;
    logic        chk_err;
    logic        busy;

    int n_vec;
    int n_miss;

    // Event record: {kind, channel, timestamp}; fields are the held output values.
    logic [35:0] exp_q[$];
    logic [1:0]  hold_ch;
    logic [31:0] hold_ts;

    ts_record_rx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'h7E)) dut (
        .clk           (clk),
        .rst           (rst),
        .serialin      (serialin),
        .rec_valid     (rec_valid),
        .rec_channel   (rec_channel),
        .rec_timestamp (rec_timestamp),
        .frame_err     (frame_err),
        .chk_err       (chk_err),
        .busy          (busy)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    // Scoreboard helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: act=%h req=%h", name, act, req);
        end
    endtask

    task automatic expect_good(input logic [1:0] ch, input logic [31:0] ts);
        hold_ch = ch;
        hold_ts = ts;
        exp_q.push_back({K_VALID, ch, ts});
    endtask

    task automatic expect_err(input logic [1:0] kind);
        exp_q.push_back({kind, hold_ch, hold_ts});
    endtask

    // Driver tasks
    task automatic idle(input int n);
        serialin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        serialin = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    // Seven bytes, first byte in the top of the vector, no gaps.
    task automatic send_rec(input logic [55:0] r);
        for (int i = 6; i >= 0; i--) send_byte(r[i*8 +: 8], 1'b1);
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (!rst && (rec_valid || chk_err || frame_err)) begin
            logic [1:0]  kind;
            logic [35:0] exp;
            case ({rec_valid, chk_err, frame_err})
                3'b100:  kind = K_VALID;
                3'b010:  kind = K_CHK;
                3'b001:  kind = K_FRAME;
                default: kind = 2'd0;
            endcase
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_event: act=%h req=none", {kind, rec_channel, rec_timestamp});
            end else begin
                exp = exp_q.pop_front();
                if ({kind, rec_channel, rec_timestamp} !== exp) begin
                    n_miss++;
                    $display("FAIL event: act=%h req=%h", {kind, rec_channel, rec_timestamp}, exp);
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_vec    = 0;
        n_miss   = 0;
        hold_ch  = 2'd0;
        hold_ts  = 32'd0;
        rst      = 1'b1;
        serialin = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {rec_valid, chk_err, frame_err, busy, rec_channel, rec_timestamp}, 64'd0);

        // Good record; checksum 01^00^00^12^34 = 27
        expect_good(2'd1, 32'h0000_1234);
        send_byte(8'h7E, 1'b1);
        check("busy_after_sync", busy, 1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h27, 1'b1);
        idle(20);

        // Bad checksum: outputs must keep the previous record
        expect_err(K_CHK);
        send_rec(56'h7E_01_00_00_12_34_00);
        idle(20);
        check("busy_after_chk_err", busy, 0);

        // Framing error on TS2, then remainder of that record is ignored noise
        expect_err(K_FRAME);
        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        check("busy_after_frame_err", busy, 0);
        idle(12 * CPB);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h27, 1'b1);
        idle(20);
        // 03^DE^AD^BE^EF = 21
        expect_good(2'd3, 32'hDEAD_BEEF);
        send_rec(56'h7E_03_DE_AD_BE_EF_21);
        idle(20);

        // Noise bytes and a short low glitch before a record; 02^CA^FE^00^05 = 33
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        idle(20);
        serialin = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        expect_good(2'd2, 32'hCAFE_0005);
        send_rec(56'h7E_02_CA_FE_00_05_33);
        idle(20);

        // Back-to-back records, first carries sync values as data
        expect_good(2'd1, 32'h7E7E_7E7E);
        expect_good(2'd3, 32'h0000_002A);
        send_rec(56'h7E_01_7E_7E_7E_7E_01);
        send_rec(56'h7E_03_00_00_00_2A_29);
        idle(20);

        // Reset partway into TS1 discards the record and clears outputs
        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        serialin = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        serialin = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_ch = 2'd0;
        hold_ts = 32'd0;
        check("outputs_after_mid_reset", {rec_valid, chk_err, frame_err, busy, rec_channel, rec_timestamp}, 64'd0);
        idle(40);
        expect_good(2'd2, 32'h0000_0001);
        send_rec(56'h7E_02_00_00_00_01_03);

        // Drain: every queued event must have been seen
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
